framebuffer_controller: RTL and testbench

- Owns the double-buffered frame memory feeding `display_driver`.
- Shares the single BRAM write port between two writers (renderer and host loader) with round-robin arbitration.
- Swaps front and back banks only inside the driver's `safe_flip` window, then optionally clears the new back bank.
- Forms the read address for the driver's BRAM fetch from its row/column counters.

---
 rtl/framebuffer_controller_pkg.sv | 15 +
 rtl/framebuffer_controller_arbiter.sv | 29 ++
 rtl/framebuffer_controller.sv | 136 +++++++++++++
 tb/tb_framebuffer_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_controller_pkg.sv
// Shared definitions for the frame buffer controller: state encodings and the
// default display geometry, which must stay in step with display_driver.
package framebuffer_controller_pkg;

  localparam int FB_DEF_ROWS    = 8;
  localparam int FB_DEF_COLUMNS = 32;
  localparam int FB_DEF_DATA_W  = 24;

  typedef enum logic [1:0] {
    FB_IDLE      = 2'd0,
    FB_FLIP_WAIT = 2'd1,
    FB_CLEAR     = 2'd2
  } fb_state_t;

endpackage

// File: rtl/framebuffer_controller_arbiter.sv
// Two-way round-robin arbiter for the shared BRAM write port.
// Grants are combinational; last_grant advances on every transfer.
module fb_rr_arbiter (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_last_grant;

  // On a tie the requester that was not served last wins.
  assign o_grant0 = i_en & i_valid0 & (~i_valid1 | r_last_grant);
  assign o_grant1 = i_en & i_valid1 & (~i_valid0 | ~r_last_grant);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last_grant <= 1'b1;
    end else if (o_grant0) begin
      r_last_grant <= 1'b0;
    end else if (o_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_controller.sv
// Double-buffered frame memory controller: arbitrated back-bank writes,
// flip synchronised to the driver's safe_flip window, and optional back-bank clear.
module framebuffer_controller
  import framebuffer_controller_pkg::*;
#(
  parameter int rows       = FB_DEF_ROWS,
  parameter int columns    = FB_DEF_COLUMNS,
  parameter int data_width = FB_DEF_DATA_W,
  localparam int RW    = $clog2(rows),
  localparam int CW    = $clog2(columns),
  localparam int AW    = RW + CW,
  localparam int DEPTH = rows * columns
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [RW-1:0]         i_row,
  input  logic [CW-1:0]         i_column,
  input  logic                  i_safe_flip,
  output logic [AW:0]           o_rd_addr,
  output logic                  o_front_bank,
  input  logic                  i_req0_valid,
  input  logic                  i_req1_valid,
  output logic                  o_req0_ready,
  output logic                  o_req1_ready,
  input  logic [AW-1:0]         i_req0_addr,
  input  logic [AW-1:0]         i_req1_addr,
  input  logic [data_width-1:0] i_req0_data,
  input  logic [data_width-1:0] i_req1_data,
  output logic                  o_wr_en,
  output logic [AW:0]           o_wr_addr,
  output logic [data_width-1:0] o_wr_data,
  input  logic                  i_flip_req,
  input  logic                  i_clear_on_flip,
  input  logic                  i_clear_req,
  output logic                  o_busy,
  output logic                  o_flip_done
);

  localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);

  fb_state_t             r_state;
  logic                  r_front_bank;
  logic                  r_clr_latch;
  logic [AW-1:0]         r_cnt;
  logic                  r_wr_en;
  logic [AW:0]           r_wr_addr;
  logic [data_width-1:0] r_wr_data;
  logic                  r_flip_done;

  logic w_arb_en;
  logic w_gnt0;
  logic w_gnt1;

  // No transfer may share a cycle with the IDLE exit, so block on pending commands.
  assign w_arb_en = (r_state == FB_IDLE) & ~i_flip_req & ~i_clear_req;

  fb_rr_arbiter u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_arb_en),
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .o_grant0 (w_gnt0),
    .o_grant1 (w_gnt1)
  );

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_rd_addr    = {r_front_bank, i_row, i_column};
  assign o_front_bank = r_front_bank;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = (r_state != FB_IDLE);
  assign o_flip_done  = r_flip_done;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= FB_IDLE;
      r_front_bank <= 1'b0;
      r_clr_latch  <= 1'b0;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_flip_done  <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_flip_done <= 1'b0;

      if (w_gnt0) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {~r_front_bank, i_req0_addr};
        r_wr_data <= i_req0_data;
      end else if (w_gnt1) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {~r_front_bank, i_req1_addr};
        r_wr_data <= i_req1_data;
      end

      case (r_state)
        FB_IDLE: begin
          if (i_flip_req) begin
            r_state     <= FB_FLIP_WAIT;
            r_clr_latch <= i_clear_on_flip;
          end else if (i_clear_req) begin
            r_state <= FB_CLEAR;
            r_cnt   <= '0;
          end
        end
        FB_FLIP_WAIT: begin
          if (i_safe_flip) begin
            r_front_bank <= ~r_front_bank;
            r_flip_done  <= 1'b1;
            r_cnt        <= '0;
            r_state      <= r_clr_latch ? FB_CLEAR : FB_IDLE;
          end
        end
        FB_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= {~r_front_bank, r_cnt};
          r_wr_data <= '0;
          // Wrap on DEPTH-1 so non-power-of-two geometries never clear past the bank.
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= FB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= FB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_controller.sv
// Directed self-checking bench for framebuffer_controller at default geometry
// (8 rows x 32 columns, 24-bit pixels).
module tb_framebuffer_controller;

  localparam int AW = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    row = '0;
  logic [4:0]    column = '0;
  logic          safe_flip = 1'b0;
  logic [AW:0]   rd_addr;
  logic          front_bank;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          flip_req = 1'b0, clear_on_flip = 1'b0, clear_req = 1'b0;
  logic          busy, flip_done;

  int n_cmp = 0;
  int n_err = 0;

  framebuffer_controller dut (
    .i_clk(clk), .i_rst(rst), .i_row(row), .i_column(column),
    .i_safe_flip(safe_flip), .o_rd_addr(rd_addr), .o_front_bank(front_bank),
    .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_addr(req0_addr), .i_req1_addr(req1_addr),
    .i_req0_data(req0_data), .i_req1_data(req1_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_flip_req(flip_req), .i_clear_on_flip(clear_on_flip), .i_clear_req(clear_req),
    .o_busy(busy), .o_flip_done(flip_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_front", 32'(front_bank), 32'h0);
    rst = 1'b1;
    step();

    // Round-robin tie: 0,1,0,1 to back bank 1
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 8'd5;  req1_addr = 8'd9;
    req0_data = 24'hAAAAAA; req1_data = 24'h555555;
    #1;
    chk("arb_first_r0", 32'(req0_ready), 32'h1);
    chk("arb_first_r1", 32'(req1_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arb_wr_en", 32'(wr_en), 32'h1);
      chk("arb_wr_addr", 32'(wr_addr), (i % 2 == 0) ? 32'd261 : 32'd265);
      chk("arb_wr_data", 32'(wr_data), (i % 2 == 0) ? 32'hAAAAAA : 32'h555555);
    end
    req0_valid = 1'b0;
    #1;
    chk("arb_single_r1", 32'(req1_ready), 32'h1);
    step();
    chk("arb_single_addr", 32'(wr_addr), 32'd265);
    req1_valid = 1'b0;
    step();
    chk("arb_idle_wr_en", 32'(wr_en), 32'h0);

    // Flip with a pending request; readies forced low
    req0_valid = 1'b1;
    flip_req = 1'b1; clear_on_flip = 1'b0;
    #1;
    chk("flip_req_block_r0", 32'(req0_ready), 32'h0);
    step();
    flip_req = 1'b0;
    chk("flip_wait_busy", 32'(busy), 32'h1);
    chk("flip_wait_no_write", 32'(wr_en), 32'h0);
    for (int i = 0; i < 9; i++) begin
      clear_req = (i == 3);
      #1;
      chk("flip_wait_r0", 32'(req0_ready), 32'h0);
      step();
    end
    clear_req = 1'b0;
    chk("flip_pre_front", 32'(front_bank), 32'h0);
    row = 3'd3; column = 5'd7;
    safe_flip = 1'b1;
    step();
    safe_flip = 1'b0;
    chk("flip_front", 32'(front_bank), 32'h1);
    chk("flip_done_hi", 32'(flip_done), 32'h1);
    chk("flip_rd_addr", 32'(rd_addr), 32'd359);
    req0_valid = 1'b0;
    step();
    chk("flip_done_lo", 32'(flip_done), 32'h0);
    chk("flip_then_idle", 32'(busy), 32'h0);

    // flip_req together with safe_flip: window ignored
    flip_req = 1'b1; safe_flip = 1'b1;
    step();
    flip_req = 1'b0; safe_flip = 1'b0;
    chk("same_cycle_front", 32'(front_bank), 32'h1);
    chk("same_cycle_busy", 32'(busy), 32'h1);
    step(); step();
    chk("same_cycle_wait", 32'(front_bank), 32'h1);
    safe_flip = 1'b1;
    step();
    safe_flip = 1'b0;
    chk("same_cycle_swap", 32'(front_bank), 32'h0);
    chk("same_cycle_done", 32'(flip_done), 32'h1);
    step();

    // Flip with clear: clear_on_flip latched at request time only
    flip_req = 1'b1; clear_on_flip = 1'b1;
    step();
    flip_req = 1'b0; clear_on_flip = 1'b0;
    step();
    safe_flip = 1'b1;
    step();
    safe_flip = 1'b0;
    chk("fc_front", 32'(front_bank), 32'h1);
    chk("fc_busy", 32'(busy), 32'h1);
    chk("fc_no_write_yet", 32'(wr_en), 32'h0);
    for (int k = 0; k < 256; k++) begin
      flip_req = (k == 10);
      step();
      chk("fc_wr_en", 32'(wr_en), 32'h1);
      chk("fc_wr_addr", 32'(wr_addr), 32'(k));
      chk("fc_wr_data", 32'(wr_data), 32'h0);
    end
    flip_req = 1'b0;
    chk("fc_busy_end", 32'(busy), 32'h0);
    step();
    chk("fc_wr_en_end", 32'(wr_en), 32'h0);
    chk("fc_front_kept", 32'(front_bank), 32'h1);
    chk("fc_still_idle", 32'(busy), 32'h0);

    // Reset in the middle of a clear
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step(); step();
    chk("mid_clr_addr", 32'(wr_addr), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("mid_rst_front", 32'(front_bank), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(flip_done), 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_wr_en", 32'(wr_en), 32'h0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_tie_r0", 32'(req0_ready), 32'h1);
    chk("post_rst_tie_r1", 32'(req1_ready), 32'h0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_rst_wr_addr", 32'(wr_addr), 32'd261);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
